hazard_scoreboard_unit: RTL

//  Parametrised next-gen hazard block. Generates per-operand forwarding selects,

---
 rtl/hazard_scoreboard_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit beside the ID/EX pipeline registers: per-operand forwarding
// selects for EX, load-use / RAW / WAW / capacity stalls for ID, and a
// scoreboard of destinations owned by outstanding long-latency ops.
`timescale 1ns/1ps
module hazard_scoreboard_unit #(
    parameter  int NUM_SRC  = 2,
    parameter  int AW       = 5,
    parameter  int MAX_LONG = 4,
    parameter  int CNT_W    = 16,
    localparam int NUM_REGS = 2**AW,
    localparam int LCW      = $clog2(MAX_LONG+1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_SRC*AW-1:0] id_rs_labels_i,
    input  logic [NUM_SRC-1:0]    id_rs_used_i,
    input  logic [AW-1:0]         id_rd_label_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_is_long_i,
    input  logic [NUM_SRC*AW-1:0] ex_rs_labels_i,
    input  logic [AW-1:0]         ex_rd_label_i,
    input  logic                  ex_reg_write_i,
    input  logic                  ex_is_load_i,
    input  logic [AW-1:0]         ex_mem_rd_label_i,
    input  logic                  ex_mem_reg_write_i,
    input  logic [AW-1:0]         mem_wb_rd_label_i,
    input  logic                  mem_wb_reg_write_i,
    input  logic                  mem_wb_is_load_i,
    input  logic                  long_issue_i,
    input  logic [AW-1:0]         long_issue_rd_i,
    input  logic                  long_done_i,
    input  logic [AW-1:0]         long_done_rd_i,
    output logic [2*NUM_SRC-1:0]  forward_sel_o,
    output logic                  stall_o,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic [LCW-1:0]        long_count_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    localparam logic [LCW-1:0] LONG_MAX = LCW'(MAX_LONG);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [LCW-1:0]      long_count_q, long_count_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic                load_use, raw_hit, waw_hit, long_full;
    logic [AW-1:0]       fwd_lbl, raw_lbl;

    // Per EX operand: EX/MEM has priority over MEM/WB; r0 never forwards.
    always_comb begin
        forward_sel_o = '0;
        fwd_lbl       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            fwd_lbl = ex_rs_labels_i[k*AW +: AW];
            if (!rst_i && fwd_lbl != '0) begin
                if (ex_mem_reg_write_i && ex_mem_rd_label_i == fwd_lbl)
                    forward_sel_o[2*k +: 2] = 2'b10;
                else if (mem_wb_reg_write_i && mem_wb_rd_label_i == fwd_lbl)
                    forward_sel_o[2*k +: 2] = mem_wb_is_load_i ? 2'b11 : 2'b01;
            end
        end
    end

    // Stall sources; a long op writing back this cycle is visible through
    // the regfile write-through, so its register no longer blocks ID.
    always_comb begin
        load_use = 1'b0;
        raw_hit  = 1'b0;
        raw_lbl  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            raw_lbl = id_rs_labels_i[k*AW +: AW];
            if (id_rs_used_i[k] && ex_is_load_i && ex_reg_write_i &&
                ex_rd_label_i != '0 && raw_lbl == ex_rd_label_i)
                load_use = 1'b1;
            if (id_rs_used_i[k] && raw_lbl != '0 && pending_q[raw_lbl] &&
                !(long_done_i && long_done_rd_i == raw_lbl))
                raw_hit = 1'b1;
        end
        waw_hit   = id_reg_write_i && id_rd_label_i != '0 && pending_q[id_rd_label_i] &&
                    !(long_done_i && long_done_rd_i == id_rd_label_i);
        long_full = id_is_long_i && long_count_q == LONG_MAX && !long_done_i;
        stall_o   = !rst_i && (load_use || raw_hit || waw_hit || long_full);
    end

    // Next scoreboard state: done clears, issue sets afterwards so issue wins.
    always_comb begin
        pending_d = pending_q;
        if (long_done_i)
            pending_d[long_done_rd_i] = 1'b0;
        if (long_issue_i && long_issue_rd_i != '0)
            pending_d[long_issue_rd_i] = 1'b1;

        long_count_d = long_count_q;
        if (long_issue_i && !long_done_i && long_count_q != LONG_MAX)
            long_count_d = long_count_q + LCW'(1);
        else if (long_done_i && !long_issue_i && long_count_q != '0)
            long_count_d = long_count_q - LCW'(1);

        stall_cycles_d = stall_cycles_q;
        if (stall_o && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q      <= '0;
            long_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            long_count_q   <= long_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending_o      = pending_q;
    assign long_count_o   = long_count_q;
    assign stall_cycles_o = stall_cycles_q;

endmodule
